// File: rtl/ah_pl2ddr_mc_sched.sv
// rtl/ah_pl2ddr_mc_sched.sv - Multi-channel round-robin burst scheduler for the PL-to-DDR write path
module ah_pl2ddr_mc_sched #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 10,
  parameter int BEAT_BYTES = 4,
  parameter int BURST_MAX  = 256,
  parameter int THRESH     = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_CH-1:0]             in_ch_en,
  input  logic [NUM_CH-1:0]             in_flush,
  input  logic [NUM_CH-1:0]             in_wrap_en,
  input  logic [NUM_CH-1:0]             in_rst_offset,
  input  logic [NUM_CH-1:0]             in_clear,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   in_avail,
  input  logic [NUM_CH*32-1:0]          in_base,
  input  logic [NUM_CH*32-1:0]          in_size,
  output logic                          out_tx_init,
  output logic [31:0]                   out_tx_addr,
  output logic [8:0]                    out_tx_len,
  output logic [2:0]                    out_tx_ch,
  input  logic                          in_tx_done,
  input  logic                          in_tx_error,
  output logic                          out_busy,
  output logic [NUM_CH-1:0]             out_sent,
  output logic [NUM_CH-1:0]             out_wrapped,
  output logic [NUM_CH-1:0]             out_error,
  output logic [2:0]                    out_state
);
  localparam int BSHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        last_grant_q, last_grant_d;
  logic [31:0]       offset_q [NUM_CH];
  logic [31:0]       offset_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] error_q, error_d;
  logic [NUM_CH-1:0] sent_q, sent_d;
  logic [NUM_CH-1:0] wrapped_q, wrapped_d;
  logic              tx_init_q, tx_init_d;
  logic              busy_q, busy_d;
  logic [31:0]       tx_addr_q, tx_addr_d;
  logic [8:0]        tx_len_q, tx_len_d;

  logic [NUM_CH-1:0]    elig;
  logic [CNT_WIDTH-1:0] sel_avail;
  logic [31:0]          sel_base, sel_size, sel_off;
  logic                 sel_wrap;
  logic                 found;
  logic [2:0]           pick;
  logic [31:0]          space, len32;
  logic                 hold, leave, do_wrap, do_adv, do_err;
  logic [NUM_CH-1:0]    rst_req;

  // Per-channel eligibility and operand select for the granted channel
  always_comb begin
    elig      = '0;
    sel_avail = '0;
    sel_base  = '0;
    sel_size  = '0;
    sel_off   = '0;
    sel_wrap  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = in_ch_en[i] && !error_q[i] &&
                ((32'(in_avail[i*CNT_WIDTH +: CNT_WIDTH]) >= 32'(THRESH)) ||
                 (in_flush[i] && (in_avail[i*CNT_WIDTH +: CNT_WIDTH] != '0)));
      if (3'(i) == grant_q) begin
        sel_avail = in_avail[i*CNT_WIDTH +: CNT_WIDTH];
        sel_base  = in_base[i*32 +: 32];
        sel_size  = in_size[i*32 +: 32];
        sel_off   = offset_q[i];
        sel_wrap  = in_wrap_en[i];
      end
    end
  end

  // Round-robin pick: channels above last_grant first, then wrap to the lowest eligible
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && elig[j] && (3'(j) > last_grant_q)) begin
        found = 1'b1;
        pick  = 3'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = 3'(j);
      end
    end
  end

  // Burst sizing: min of data available, max burst and beats left in the region
  always_comb begin
    space = (sel_off >= sel_size) ? '0 : ((sel_size - sel_off) >> BSHIFT);
    len32 = 32'(sel_avail);
    if (len32 > 32'(BURST_MAX)) len32 = 32'(BURST_MAX);
    if (len32 > space) len32 = space;
  end

  // Next-state, datapath and per-channel bookkeeping
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    offset_d     = offset_q;
    pend_d       = pend_q;
    error_d      = error_q & ~in_clear;
    sent_d       = '0;
    wrapped_d    = '0;
    tx_init_d    = 1'b0;
    tx_addr_d    = tx_addr_q;
    tx_len_d     = tx_len_q;
    leave        = 1'b0;
    do_wrap      = 1'b0;
    do_adv       = 1'b0;
    do_err       = 1'b0;
    hold         = (state_q == S_CALC) || (state_q == S_START) || (state_q == S_WAIT_TX);
    rst_req      = pend_q | in_rst_offset;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (space == '0) begin
          if (sel_wrap) begin
            do_wrap = 1'b1;
          end else begin
            do_err  = 1'b1;
            state_d = S_FAIL;
          end
        end else if (len32 == '0) begin
          leave   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tx_addr_d = sel_base + sel_off;
          tx_len_d  = len32[8:0];
          tx_init_d = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        // Error takes priority over done so a failed burst never advances the ring
        if (in_tx_error) begin
          do_err       = 1'b1;
          leave        = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_FAIL;
        end else if (in_tx_done) begin
          do_adv       = 1'b1;
          leave        = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      if (hold && (3'(i) == grant_q)) begin
        if (do_wrap) begin
          offset_d[i]  = '0;
          wrapped_d[i] = 1'b1;
        end
        if (do_adv) begin
          offset_d[i] = offset_q[i] + (32'(tx_len_q) << BSHIFT);
          sent_d[i]   = 1'b1;
        end
        if (do_err) error_d[i] = 1'b1;
        // Offset reset on the active channel waits until the burst is retired, then wins over the advance
        if (leave && rst_req[i]) begin
          offset_d[i] = '0;
          pend_d[i]   = 1'b0;
        end else begin
          pend_d[i] = rst_req[i];
        end
      end else if (rst_req[i]) begin
        offset_d[i] = '0;
        pend_d[i]   = 1'b0;
      end
    end

    busy_d = (state_d == S_CALC) || (state_d == S_START) || (state_d == S_WAIT_TX);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) offset_q[i] <= '0;
      pend_q       <= '0;
      error_q      <= '0;
      sent_q       <= '0;
      wrapped_q    <= '0;
      tx_init_q    <= 1'b0;
      busy_q       <= 1'b0;
      tx_addr_q    <= '0;
      tx_len_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      offset_q     <= offset_d;
      pend_q       <= pend_d;
      error_q      <= error_d;
      sent_q       <= sent_d;
      wrapped_q    <= wrapped_d;
      tx_init_q    <= tx_init_d;
      busy_q       <= busy_d;
      tx_addr_q    <= tx_addr_d;
      tx_len_q     <= tx_len_d;
    end
  end

  assign out_tx_init = tx_init_q;
  assign out_tx_addr = tx_addr_q;
  assign out_tx_len  = tx_len_q;
  assign out_tx_ch   = grant_q;
  assign out_busy    = busy_q;
  assign out_sent    = sent_q;
  assign out_wrapped = wrapped_q;
  assign out_error   = error_q;
  assign out_state   = state_q;

endmodule

// File: doc/ah_pl2ddr_mc_sched.md
# ah_pl2ddr_mc_sched

Multi-channel transfer scheduler for the PL-to-DDR path. It generalises the single-stream command FSM to NUM_CH independent sample buffers. Each channel owns a DDR ring region, and the scheduler arbitrates round-robin among channels with pending data. For the granted channel it sizes a burst against data available, maximum burst length and remaining region space, then drives the shared AXI burst-write master. It also adds per-channel ring wrap-around and per-channel error isolation.

## Interface
- NUM_CH, 4: number of channels (1–8).
- CNT_WIDTH, 10: width of each per-channel data-available count.
- BEAT_BYTES, 4: bytes per AXI beat; power of two.
- BURST_MAX, 256: maximum beats per burst (≤256).
- THRESH, 256: beats available that make a channel eligible without flush.
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_ch_en  in  NUM_CH  per-channel enable.
- in_flush  in  NUM_CH  level; channel eligible with any data > 0.
- in_wrap_en  in  NUM_CH  1 = ring wrap, 0 = stop with overflow error at region end.
- in_rst_offset  in  NUM_CH  pulse; reset channel write offset to 0.
- in_clear  in  NUM_CH  pulse; clear channel error.
- in_avail  in  NUM_CH*CNT_WIDTH  beats buffered per channel, packed with ch0 in the LSBs.
- in_base  in  NUM_CH*32  region base byte address per channel.
- in_size  in  NUM_CH*32  region size in bytes per channel; multiple of BEAT_BYTES.
- out_tx_init  out  1  one-cycle burst start.
- out_tx_addr  out  32  burst byte address.
- out_tx_len  out  9  beats in the burst (1..BURST_MAX).
- out_tx_ch  out  3  granted channel index; also selects the buffer read mux.
- in_tx_done  in  1  pulse; burst complete.
- in_tx_error  in  1  pulse; AXI error, sampled only in WAIT_TX.
- out_busy  out  1  high from CALC through WAIT_TX.
- out_sent  out  NUM_CH  one-cycle pulse per completed burst.
- out_wrapped  out  NUM_CH  one-cycle pulse when a channel offset wraps.
- out_error  out  NUM_CH  sticky error flag.
- out_state  out  3  FSM state code.

## Operation
- State codes: IDLE=0, CALC=1, START=2, WAIT_TX=3, FAIL=4.
- Eligibility: channel i is eligible when in_ch_en[i] && !out_error[i] && (avail[i] ≥ THRESH || (in_flush[i] && avail[i] > 0)).
- IDLE: search starts at (last_grant+1) mod NUM_CH and takes the first eligible channel. The grant is latched and the FSM moves to CALC. last_grant is reset to NUM_CH-1, so ch0 has first priority.
- Burst sizing in CALC:
  - space = (size − offset) / BEAT_BYTES, a shift.
  - len = min(avail, BURST_MAX, space), latched into out_tx_len.
  - out_tx_addr = base + offset (32-bit, modulo 2^32).
  - If len > 0, go to START.
- Region end, space == 0:
  - With wrap_en: offset ← 0, pulse out_wrapped[i], stay in CALC for one more cycle to recompute.
  - Without wrap_en: set out_error[i] and go to FAIL.
- Empty: if avail dropped to 0, return to IDLE with no burst.
- START: out_tx_init = 1 for exactly one cycle, then WAIT_TX.
- WAIT_TX:
  - On in_tx_done: offset[i] ← offset[i] + len*BEAT_BYTES, pulse out_sent[i], last_grant ← i, go to IDLE.
  - On in_tx_error: set out_error[i], last_grant ← i, go to FAIL.
  - If done and error arrive in the same cycle, error wins and the offset is not advanced.
- FAIL: one cycle, then IDLE. Other channels continue to be served; the errored channel is skipped until in_clear[i].
- in_rst_offset[i]:
  - Applies next cycle unless channel i is granted and the FSM is in CALC, START or WAIT_TX.
  - In that case it is held pending and applied on the cycle the FSM leaves WAIT_TX or FAIL. The reset overrides the advance.
- in_clear[i]: clears out_error[i] next cycle, in any state.
- Disabling a channel mid-transfer does not abort the burst; it only affects future arbitration.

## Timing
- Reset (rstn low, asynchronous) values:
  - State IDLE.
  - All offsets 0; last_grant = NUM_CH-1.
  - out_tx_init=0, out_tx_addr=0, out_tx_len=0, out_tx_ch=0.
  - out_busy=0, out_sent=0, out_wrapped=0, out_error=0, out_state=0.
- Deassertion is used synchronously.
- Latency: eligible in IDLE at cycle n → CALC at n+1 → out_tx_init at n+2 (n+3 if a wrap occurred).
- out_tx_addr, out_tx_len and out_tx_ch are stable from START until the FSM leaves WAIT_TX.
- Back-to-back service: done at cycle m → IDLE at m+1 → next out_tx_init at m+3 at the earliest.
- Reset asserted mid-burst: everything returns to the reset values; the AXI master is reset by the same rstn.

## Test plan
- Single channel: ch0 en, avail=300, size=4096, base=0x1000_0000 → out_tx_init with addr 0x1000_0000, len 256; after done, offset=1024 and out_sent[0] pulses.
- Round-robin: ch0..ch3 all avail=256 → grants in order 0,1,2,3,0 with each out_tx_ch matching; no channel is skipped.
- Wrap: size=1024, offset=768, avail=256, flush, wrap_en=1 → first burst len 64 at base+768; the next CALC wraps, pulses out_wrapped, and issues the next burst at base.
- Overflow without wrap: same setup with wrap_en=0 → after the len-64 burst, out_error set and the channel is skipped; in_clear plus in_rst_offset resumes service at base.
- Simultaneous in_tx_done and in_tx_error on ch2 → out_error[2]=1, offset unchanged, FSM goes FAIL→IDLE, and ch3 is served next.
- Pending offset reset: in_rst_offset[1] pulsed during ch1 WAIT_TX → after done, offset[1]=0 rather than the advanced value.
